// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a vector of unsigned 16-bit products into one dot-product
// result. Products arrive on a valid/ready handshake. Each finished result is held
// in an output register until the consumer takes it.
module mac_accumulator #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      prod,
  input  logic             prod_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t           state_q;
  state_t           state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic             accept;
  logic             close;
  logic [ACC_W-1:0] base;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_base;
  logic             ovf_next;
  logic [ACC_W:0]   sum;

  // A pending result is held in HOLD, so out_valid is simply the state.
  assign out_valid = (state_q == HOLD);

  // Ready whenever no result is stuck; in HOLD a beat may enter only in the cycle the result leaves.
  always_comb begin
    prod_ready = 1'b0;
    if (!rst) begin
      prod_ready = (state_q == HOLD) ? out_ready : 1'b1;
    end
  end

  // Datapath for an accepted beat: a new vector starts from zero unless a partial sum is in progress.
  always_comb begin
    base     = '0;
    cnt_base = '0;
    ovf_base = 1'b0;
    if (state_q == ACC) begin
      base     = acc_q;
      cnt_base = cnt_q;
      ovf_base = ovf_q;
    end
    sum      = {1'b0, base} + (ACC_W + 1)'(prod);
    cnt_next = cnt_base + CNT_W'(1);
    ovf_next = ovf_base | sum[ACC_W];
    accept   = prod_valid && prod_ready;
    close    = prod_last || (cnt_next == MAX_CNT);
  end

  // Next-state logic: a closing beat always lands in HOLD, an open beat in ACC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          state_d = close ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            state_d = close ? HOLD : ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, running sum and result registers; reset throws away any partial or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= sum[ACC_W-1:0];
        cnt_q <= cnt_next;
        ovf_q <= ovf_next;
        if (close) begin
          out_sum   <= sum[ACC_W-1:0];
          out_count <= cnt_next;
          out_ovf   <= ovf_next;
          out_trunc <= !prod_last;
        end
      end
    end
  end

endmodule
